eth_frame_sender: RTL

ETH_FRAME_SENDER -- requirements
Module: eth_frame_sender

---
 rtl/eth_frame_sender.sv | 137 +++++++++++++
 1 files changed

// File: rtl/eth_frame_sender.sv
// -----------------------------------------------------------------------------
// eth_frame_sender
//
// Sends one Ethernet frame per accepted command: an Ethernet header beat
// (dest MAC, src MAC, EtherType) and then cmd_len payload bytes read in order
// from an external buffer. The buffer has a one-cycle read latency.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   cmd_valid / cmd_ready     frame request handshake
//   cmd_len                   payload byte count (0 = no header, no payload)
//   cmd_dest_mac, cmd_src_mac header MAC addresses
//   cmd_type                  header EtherType
//   busy                      high while a frame is in progress
//   done                      one-cycle pulse when a frame completes
//   buf_raddr / buf_rdata     payload buffer read port (data one cycle later)
//   tx_busy                   downstream busy; only blocks new commands
//   s_eth_hdr_*               header output with valid/ready handshake
//   s_eth_payload_axis_*      AXI-Stream payload bytes (tuser is always 0)
// -----------------------------------------------------------------------------
module eth_frame_sender #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [47:0]       cmd_dest_mac,
    input  logic [47:0]       cmd_src_mac,
    input  logic [15:0]       cmd_type,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] buf_raddr,
    input  logic [7:0]        buf_rdata,
    input  logic              tx_busy,
    output logic              s_eth_hdr_valid,
    input  logic              s_eth_hdr_ready,
    output logic [47:0]       s_eth_dest_mac,
    output logic [47:0]       s_eth_src_mac,
    output logic [15:0]       s_eth_type,
    output logic [7:0]        s_eth_payload_axis_tdata,
    output logic              s_eth_payload_axis_tvalid,
    input  logic              s_eth_payload_axis_tready,
    output logic              s_eth_payload_axis_tlast,
    output logic              s_eth_payload_axis_tuser
);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        STREAM,
        DONE
    } state_t;

    state_t           state, state_next;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] ptr, ptr_next;     // index of the byte currently on tdata
    logic [47:0]      dest_r, src_r;
    logic [15:0]      type_r;
    logic             accept;
    logic             last_beat;

    assign cmd_ready = (state == IDLE) && !tx_busy && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign last_beat = (ptr == len_r - LEN_W'(1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            len_r  <= '0;
            dest_r <= '0;
            src_r  <= '0;
            type_r <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            if (accept) begin
                len_r  <= cmd_len;
                dest_r <= cmd_dest_mac;
                src_r  <= cmd_src_mac;
                type_r <= cmd_type;
            end
        end
    end

    // NOTE: every signal written here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                if (accept) begin
                    ptr_next   = '0;
                    state_next = (cmd_len == '0) ? DONE : HDR;
                end
            end
            HDR: begin
                if (s_eth_hdr_ready) state_next = STREAM;
            end
            STREAM: begin
                if (s_eth_payload_axis_tready) begin
                    if (last_beat) state_next = DONE;
                    else           ptr_next   = ptr + LEN_W'(1);
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The read address is the index of the byte to show next cycle. While a
    // beat is stalled it stays on the current index, so the buffer keeps
    // returning the same byte and tdata holds. In HDR this is 0, which
    // prefetches byte 0 for the first STREAM cycle. It never moves past
    // len-1 because the pointer stops advancing on the last beat.
    assign buf_raddr = (state == STREAM) ? ADDR_W'(ptr_next) : '0;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    assign s_eth_hdr_valid = (state == HDR);
    assign s_eth_dest_mac  = dest_r;
    assign s_eth_src_mac   = src_r;
    assign s_eth_type      = type_r;

    assign s_eth_payload_axis_tvalid = (state == STREAM);
    assign s_eth_payload_axis_tdata  = (state == STREAM) ? buf_rdata : 8'h00;
    assign s_eth_payload_axis_tlast  = (state == STREAM) && last_beat;
    assign s_eth_payload_axis_tuser  = 1'b0;

endmodule
